// File: rtl/spi_peripheral.sv
// SPI responder oversampled on the local clock: synchronized SCLK/CS_N/COPI,
// MSB-first byte deserializer and a one-deep reply holding register.
`timescale 1ns/1ps
module spi_peripheral #(
  parameter logic [1:0] SPI_MODE        = 2'd0,
  parameter logic [7:0] DEFAULT_TX_BYTE = 8'h05,
  parameter int         SYNC_STAGES     = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_copi,
  output logic       o_spi_cipo,
  output logic       o_spi_cipo_oe,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_busy
);
  localparam logic CPOL = SPI_MODE[1];
  localparam logic CPHA = SPI_MODE[0];
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SELECTED = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, copi_sync_r;
  logic       sclk_prev_r, cs_prev_r;
  logic [0:0] state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] tx_shift_r, rx_shift_r, hold_r, rx_byte_r;
  logic       tx_ready_r, underrun_r, rx_dv_r;
  logic       sclk_s, cs_s, copi_s, rise_s, fall_s, lead_s, trail_s;
  logic       sample_s, drive_s, cs_fall_s, cs_rise_s, byte_done_s, load_s;
  logic [7:0] load_byte_s;

  // Synchronizer chains plus one extra sample for edge detection
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_sync_r <= {SYNC_STAGES{CPOL}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      copi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= CPOL;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], i_spi_clk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], i_spi_cs_n};
      copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], i_spi_copi};
      sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
      cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  // Edge classification by mode and load decision
  always_comb begin
    sclk_s    = sclk_sync_r[SYNC_STAGES-1];
    cs_s      = cs_sync_r[SYNC_STAGES-1];
    copi_s    = copi_sync_r[SYNC_STAGES-1];
    rise_s    = sclk_s & ~sclk_prev_r;
    fall_s    = ~sclk_s & sclk_prev_r;
    cs_fall_s = cs_prev_r & ~cs_s;
    cs_rise_s = ~cs_prev_r & cs_s;
    if (CPOL) begin
      lead_s  = fall_s;
      trail_s = rise_s;
    end else begin
      lead_s  = rise_s;
      trail_s = fall_s;
    end
    if (CPHA) begin
      sample_s = trail_s;
      drive_s  = lead_s;
    end else begin
      sample_s = lead_s;
      drive_s  = trail_s;
    end
    // A CS_N rise in the same cycle as an SCLK edge drops the edge
    byte_done_s = (state_r == ST_SELECTED) && !cs_rise_s && sample_s && (bit_cnt_r == 3'd7);
    load_s      = ((state_r == ST_IDLE) && cs_fall_s) || byte_done_s;
    load_byte_s = tx_ready_r ? DEFAULT_TX_BYTE : hold_r;
  end

  // Reply holding register handshake
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_ready_r <= 1'b1;
      hold_r     <= 8'h00;
    end else if (load_s && !tx_ready_r) begin
      tx_ready_r <= 1'b1;
    end else if (i_tx_dv && tx_ready_r) begin
      tx_ready_r <= 1'b0;
      hold_r     <= i_tx_byte;
    end
  end

  // Frame state, bit counter and receive path
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_byte_r  <= 8'h00;
      rx_dv_r    <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      rx_dv_r    <= byte_done_s;
      underrun_r <= load_s & tx_ready_r;
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r   <= ST_SELECTED;
            bit_cnt_r <= 3'd0;
          end
        end
        ST_SELECTED: begin
          if (cs_rise_s) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 8'h00;
          end else if (sample_s) begin
            rx_shift_r <= {rx_shift_r[6:0], copi_s};
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              rx_byte_r <= {rx_shift_r[6:0], copi_s};
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= 3'd0;
        end
      endcase
    end
  end

  // Transmit shifter; no shift at bit 0 keeps the freshly loaded MSB on the line
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_shift_r <= 8'h00;
    end else if (load_s) begin
      tx_shift_r <= load_byte_s;
    end else if ((state_r == ST_SELECTED) && !cs_rise_s && drive_s && (bit_cnt_r != 3'd0)) begin
      tx_shift_r <= {tx_shift_r[6:0], 1'b0};
    end
  end

  assign o_spi_cipo    = tx_shift_r[7];
  assign o_spi_cipo_oe = ~cs_sync_r[SYNC_STAGES-1];
  assign o_tx_ready    = tx_ready_r;
  assign o_tx_underrun = underrun_r;
  assign o_rx_byte     = rx_byte_r;
  assign o_rx_dv       = rx_dv_r;
  assign o_busy        = (state_r == ST_SELECTED);
endmodule
